// File: rtl/memory_access.sv
// Memory-access pipeline stage: pass-through, load or store against an internal
// word-addressed data memory with a configurable number of wait states.
module memory_access #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] b_ex,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic              mem_mux_sel,
    output logic [DATA_W-1:0] ans_dm,
    output logic              valid_dm,
    output logic              stall
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);
    localparam logic       HAS_WAIT = (WAIT_STATES != 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_nxt_s;

    // Operand copies held for the duration of a multi-cycle access.
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_W-1:0]   store_r;
    logic [DATA_W-1:0]   store_nxt_s;
    logic [DATA_W-1:0]   ans_lat_r;
    logic [DATA_W-1:0]   ans_lat_nxt_s;
    logic                rw_r;
    logic                rw_nxt_s;
    logic                sel_r;
    logic                sel_nxt_s;

    logic [ADDR_W-1:0]   op_addr_s;
    logic [DATA_W-1:0]   op_data_s;
    logic [DATA_W-1:0]   op_ans_s;
    logic                op_rw_s;
    logic                op_sel_s;
    logic [DATA_W-1:0]   rd_data_s;

    logic                done_s;
    logic                stall_s;
    logic                wr_en_s;
    logic [DATA_W-1:0]   ans_nxt_s;
    logic                valid_nxt_s;
    logic [DATA_W-1:0]   ans_dm_r;
    logic                valid_dm_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Select live inputs in IDLE and the latched copies while BUSY.
    always_comb begin
        op_addr_s = ans_ex[ADDR_W-1:0];
        op_data_s = b_ex;
        op_ans_s  = ans_ex;
        op_rw_s   = mem_rw;
        op_sel_s  = mem_mux_sel;
        if (state_r == BUSY) begin
            op_addr_s = addr_r;
            op_data_s = store_r;
            op_ans_s  = ans_lat_r;
            op_rw_s   = rw_r;
            op_sel_s  = sel_r;
        end else begin
            op_addr_s = ans_ex[ADDR_W-1:0];
        end
    end

    assign rd_data_s = mem_r[op_addr_s];

    // Next-state, completion and stall decode.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        addr_nxt_s    = addr_r;
        store_nxt_s   = store_r;
        ans_lat_nxt_s = ans_lat_r;
        rw_nxt_s      = rw_r;
        sel_nxt_s     = sel_r;
        done_s        = 1'b0;
        stall_s       = 1'b0;
        wr_en_s       = 1'b0;
        ans_nxt_s     = ans_dm_r;
        valid_nxt_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (valid_ex) begin
                    if (!mem_en) begin
                        ans_nxt_s   = ans_ex;
                        valid_nxt_s = 1'b1;
                    end else if (HAS_WAIT) begin
                        stall_s       = 1'b1;
                        addr_nxt_s    = ans_ex[ADDR_W-1:0];
                        store_nxt_s   = b_ex;
                        ans_lat_nxt_s = ans_ex;
                        rw_nxt_s      = mem_rw;
                        sel_nxt_s     = mem_mux_sel;
                        cnt_nxt_s     = WAIT_CNT;
                        state_nxt_s   = BUSY;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            BUSY: begin
                // Final wait cycle releases upstream while the access completes.
                if (cnt_r != 3'd1) begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r - 3'd1;
                end else begin
                    done_s      = 1'b1;
                    cnt_nxt_s   = 3'd0;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase

        if (done_s) begin
            if (op_rw_s) begin
                wr_en_s = 1'b1;
            end else begin
                ans_nxt_s   = op_sel_s ? rd_data_s : op_ans_s;
                valid_nxt_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // State, latched operands and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            addr_r     <= '0;
            store_r    <= '0;
            ans_lat_r  <= '0;
            rw_r       <= 1'b0;
            sel_r      <= 1'b0;
            ans_dm_r   <= '0;
            valid_dm_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            addr_r     <= addr_nxt_s;
            store_r    <= store_nxt_s;
            ans_lat_r  <= ans_lat_nxt_s;
            rw_r       <= rw_nxt_s;
            sel_r      <= sel_nxt_s;
            ans_dm_r   <= ans_nxt_s;
            valid_dm_r <= valid_nxt_s;
        end
    end

    // Memory array write port; contents survive reset but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[op_addr_s] <= op_data_s;
        end
    end

    assign ans_dm   = ans_dm_r;
    assign valid_dm = valid_dm_r;
    assign stall    = stall_s;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one instance with 1 wait state, one with 3.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_a;
    logic        valid_b;
    logic [15:0] ans_ex;
    logic [15:0] b_ex;
    logic        mem_en;
    logic        mem_rw;
    logic        mem_mux_sel;
    logic [15:0] ans_a, ans_b;
    logic        vld_a, vld_b;
    logic        stall_a, stall_b;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_access #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .valid_ex(valid_a), .ans_ex(ans_ex), .b_ex(b_ex),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_mux_sel(mem_mux_sel),
        .ans_dm(ans_a), .valid_dm(vld_a), .stall(stall_a));

    memory_access #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .valid_ex(valid_b), .ans_ex(ans_ex), .b_ex(b_ex),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_mux_sel(mem_mux_sel),
        .ans_dm(ans_b), .valid_dm(vld_b), .stall(stall_b));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic en, input logic rw, input logic sel,
                          input logic [15:0] a, input logic [15:0] b);
        mem_en      = en;
        mem_rw      = rw;
        mem_mux_sel = sel;
        ans_ex      = a;
        b_ex        = b;
    endtask

    initial begin
        reset   = 1'b1;
        valid_a = 1'b1;
        valid_b = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);

        // Reset held two cycles with a pass-through presented
        tick();
        tick();
        chk("rst_ans_a", ans_a, 16'h0000);
        chk("rst_vld_a", {15'd0, vld_a}, 16'd0);
        chk("rst_stall_a", {15'd0, stall_a}, 16'd0);
        chk("rst_ans_b", ans_b, 16'h0000);
        chk("rst_vld_b", {15'd0, vld_b}, 16'd0);
        reset = 1'b0;
        tick();
        chk("pass_ans_a", ans_a, 16'h1234);
        chk("pass_vld_a", {15'd0, vld_a}, 16'd1);
        chk("pass_ans_b", ans_b, 16'h1234);
        valid_b = 1'b0;

        // WS=1 store BEEF to address 5
        set_op(1'b1, 1'b1, 1'b0, 16'h0005, 16'hBEEF);
        #1 chk("st_stall_idle", {15'd0, stall_a}, 16'd1);
        tick();
        chk("st_stall_busy", {15'd0, stall_a}, 16'd0);
        chk("st_vld_busy", {15'd0, vld_a}, 16'd0);
        tick();
        chk("st_vld_done", {15'd0, vld_a}, 16'd0);
        chk("st_ans_hold", ans_a, 16'h1234);

        // WS=1 load address 5 from memory
        set_op(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
        #1 chk("ld_stall_idle", {15'd0, stall_a}, 16'd1);
        tick();
        chk("ld_vld_busy", {15'd0, vld_a}, 16'd0);
        chk("ld_stall_busy", {15'd0, stall_a}, 16'd0);
        tick();
        chk("ld_ans", ans_a, 16'hBEEF);
        chk("ld_vld", {15'd0, vld_a}, 16'd1);

        // Address wrap: store at 0x105 lands on word 5
        set_op(1'b1, 1'b1, 1'b0, 16'h0105, 16'hA5A5);
        tick();
        chk("wrap_vld_pulse", {15'd0, vld_a}, 16'd0);
        tick();
        set_op(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
        tick();
        tick();
        chk("wrap_ans", ans_a, 16'hA5A5);
        chk("wrap_vld", {15'd0, vld_a}, 16'd1);

        // Load with mux select 0 returns ans_ex
        set_op(1'b1, 1'b0, 1'b0, 16'h0077, 16'h0000);
        tick();
        tick();
        chk("sel0_ans", ans_a, 16'h0077);
        chk("sel0_vld", {15'd0, vld_a}, 16'd1);

        // Reset mid-op: seed 2222 at address 9, then abort a store of 1111
        set_op(1'b1, 1'b1, 1'b0, 16'h0009, 16'h2222);
        tick();
        tick();
        set_op(1'b1, 1'b1, 1'b0, 16'h0009, 16'h1111);
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        valid_a = 1'b0;
        #1 chk("abort_stall", {15'd0, stall_a}, 16'd0);
        chk("abort_ans", ans_a, 16'h0000);
        chk("abort_vld", {15'd0, vld_a}, 16'd0);
        valid_a = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 16'h0009, 16'h0000);
        tick();
        tick();
        chk("abort_ld_ans", ans_a, 16'h2222);
        chk("abort_ld_vld", {15'd0, vld_a}, 16'd1);
        valid_a = 1'b0;
        tick();
        chk("abort_vld_pulse", {15'd0, vld_a}, 16'd0);

        // WS=3 store C3C3 to address 0x20
        valid_b = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, 16'h0020, 16'hC3C3);
        #1 chk("w3_st_stall0", {15'd0, stall_b}, 16'd1);
        tick();
        chk("w3_st_stall1", {15'd0, stall_b}, 16'd1);
        tick();
        chk("w3_st_stall2", {15'd0, stall_b}, 16'd1);
        tick();
        chk("w3_st_stall3", {15'd0, stall_b}, 16'd0);
        tick();
        chk("w3_st_vld", {15'd0, vld_b}, 16'd0);

        // WS=3 load of 0x20 with inputs changing while BUSY
        set_op(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
        #1 chk("w3_ld_stall0", {15'd0, stall_b}, 16'd1);
        tick();
        set_op(1'b1, 1'b1, 1'b0, 16'h0030, 16'hFFFF);
        #1 chk("w3_ld_stall1", {15'd0, stall_b}, 16'd1);
        chk("w3_ld_vld1", {15'd0, vld_b}, 16'd0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        #1 chk("w3_ld_stall2", {15'd0, stall_b}, 16'd1);
        tick();
        valid_b = 1'b0;
        #1 chk("w3_ld_stall3", {15'd0, stall_b}, 16'd0);
        chk("w3_ld_vld3", {15'd0, vld_b}, 16'd0);
        tick();
        chk("w3_ld_ans", ans_b, 16'hC3C3);
        chk("w3_ld_vld", {15'd0, vld_b}, 16'd1);
        tick();
        chk("w3_vld_pulse", {15'd0, vld_b}, 16'd0);
        chk("w3_ans_hold", ans_b, 16'hC3C3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
